shift_seq_8bit: RTL and testbench
=================================

SHIFT_SEQ_8BIT -- requirements
Module: shift_seq_8bit

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the data path width in bits.
REQ-002 Parameter AMT_W, default 3, SHALL set the shift-amount width and SHALL equal $clog2(WIDTH).
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 start  input  1  SHALL request an operation; sampled only in IDLE.
REQ-006 op  input  2  SHALL select 00=SLL, 01=SRL, 10=SRA, 11=ROL.
REQ-007 amt  input  AMT_W  SHALL give the shift/rotate distance in bits.
REQ-008 in  input  WIDTH  SHALL be the operand.
REQ-009 out  output  WIDTH  SHALL be the result register.
REQ-010 busy  output  1  SHALL be high in SHIFT and DONE.
REQ-011 done  output  1  SHALL pulse high for exactly one cycle when out is final.

Function
REQ-012 FSM states SHALL be IDLE, SHIFT and DONE.
REQ-013 IDLE with start=1 at edge N SHALL latch op, load out<=in, load cnt<=amt, and go to SHIFT.
REQ-014 SHIFT with cnt!=0 SHALL move out by one bit, decrement cnt, and remain in SHIFT.
REQ-015 SHIFT with cnt==0 SHALL go to DONE without modifying out.
REQ-016 DONE SHALL assert done and go to IDLE on the next edge.
REQ-017 For amt=k, done SHALL be high between edges N+k+1 and N+k+2; amt=0 gives done after edge N+1 with out==in.
REQ-018 SLL SHALL insert 0 at bit 0; SRL SHALL insert 0 at bit WIDTH-1.
REQ-019 SRA SHALL replicate bit WIDTH-1 into bit WIDTH-1.
REQ-020 ROL SHALL move bit WIDTH-1 into bit 0.
REQ-021 start asserted in SHIFT or DONE SHALL be ignored, with no queuing.
REQ-022 Changes on op, amt or in after edge N SHALL NOT affect the operation in progress.
REQ-023 out SHALL hold its final value in IDLE until the next accepted start.
REQ-024 busy and done SHALL be decoded from registered state only, with no combinational path from inputs.

Reset
REQ-025 rst_n=0 SHALL immediately force state=IDLE, out=0, cnt=0, busy=0 and done=0, regardless of clk.
REQ-026 Reset asserted during SHIFT or DONE SHALL abort the operation, with no done pulse after release.
REQ-027 The first start after rst_n rises SHALL be accepted at the first rising edge with rst_n=1.

Configuration
REQ-028 Macro SHIFT_SEQ_ZERO_FLAG_EN, when defined, SHALL add output zero (1 bit), registered and updated on entry to DONE, equal to 1 if and only if out==0, and held until the next DONE entry.
REQ-029 The zero flag SHALL reset to 0.
REQ-030 Without SHIFT_SEQ_ZERO_FLAG_EN, the zero port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-031 in=0x81, op=ROL, amt=1, start at edge N -> out=0x03; done high after edge N+2 only; busy low after edge N+3.
REQ-032 in=0x96, op=SRA, amt=3 -> out=0xF2; done after edge N+4; in=0x96, op=SRL, amt=3 -> out=0x12.
REQ-033 in=0xFF, op=SLL, amt=7 -> out=0x80 after 8 edges; in=0x5A, amt=0 -> out=0x5A, done after edge N+1.
REQ-034 Start 0x0F SLL 4, then re-assert start with in=0xAA at N+2 -> ignored; out=0xF0; single done pulse.
REQ-035 Start SRL 5, drop rst_n mid-SHIFT asynchronously -> out=0, busy=0 immediately; no done; a new start after release completes normally.
REQ-036 With SHIFT_SEQ_ZERO_FLAG_EN: in=0x01, SRL, amt=1 -> zero=1 with done; then in=0x03, SRL, amt=1 -> zero=0.

Source files
------------

// File: rtl/shift_seq_8bit.sv
// Sequential shifter: one bit per cycle (SLL, SRL, SRA, ROL) through IDLE -> SHIFT -> DONE.
// Optional feature macro SHIFT_SEQ_ZERO_FLAG_EN adds a registered zero-result flag output.
module shift_seq_8bit #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [AMT_W-1:0] amt,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out,
    output logic             busy,
`ifdef SHIFT_SEQ_ZERO_FLAG_EN
    output logic             zero,
`endif
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;
    localparam logic [1:0] OP_ROL = 2'b11;

    state_t           state_reg;
    state_t           state_next;
    logic [1:0]       op_reg;
    logic [AMT_W-1:0] cnt_reg;
    logic [WIDTH-1:0] out_reg;
    logic [WIDTH-1:0] out_next;

    logic [WIDTH-1:0] shl_step;
    logic [WIDTH-1:0] srl_step;
    logic [WIDTH-1:0] sra_step;
    logic [WIDTH-1:0] rol_step;

    // Single-bit move for each operation; only the edge bits differ between them.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_step
            if (gi == 0) begin : g_lsb
                assign shl_step[gi] = 1'b0;
                assign rol_step[gi] = out_reg[WIDTH-1];
            end else begin : g_lsb_n
                assign shl_step[gi] = out_reg[gi-1];
                assign rol_step[gi] = out_reg[gi-1];
            end
            if (gi == WIDTH-1) begin : g_msb
                assign srl_step[gi] = 1'b0;
                assign sra_step[gi] = out_reg[WIDTH-1];
            end else begin : g_msb_n
                assign srl_step[gi] = out_reg[gi+1];
                assign sra_step[gi] = out_reg[gi+1];
            end
        end
    endgenerate

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = SHIFT;
            SHIFT:   if (cnt_reg == '0) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs decoded from the registered state only
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state_reg)
            SHIFT:   busy = 1'b1;
            DONE:    begin busy = 1'b1; done = 1'b1; end
            default: ;
        endcase
    end

    always_comb begin
        out_next = out_reg;
        case (op_reg)
            OP_SLL:  out_next = shl_step;
            OP_SRL:  out_next = srl_step;
            OP_SRA:  out_next = sra_step;
            OP_ROL:  out_next = rol_step;
            default: out_next = out_reg;
        endcase
    end

    // Operands are captured only on acceptance so later input changes cannot leak in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_reg  <= OP_SLL;
            cnt_reg <= '0;
            out_reg <= '0;
        end else begin
            if (state_reg == IDLE && start) begin
                op_reg  <= op;
                cnt_reg <= amt;
                out_reg <= in;
            end else if (state_reg == SHIFT && cnt_reg != '0) begin
                out_reg <= out_next;
                cnt_reg <= cnt_reg - 1'b1;
            end
        end
    end

    assign out = out_reg;

`ifdef SHIFT_SEQ_ZERO_FLAG_EN
    logic zero_reg;

    // out is not modified on the SHIFT->DONE edge, so out_reg already holds the final value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zero_reg <= 1'b0;
        end else if (state_reg == SHIFT && cnt_reg == '0) begin
            zero_reg <= (out_reg == '0);
        end
    end

    assign zero = zero_reg;
`endif

endmodule

// File: tb/tb_shift_seq_8bit.sv
// Directed self-checking bench for shift_seq_8bit (also covers the zero flag when
// SHIFT_SEQ_ZERO_FLAG_EN is defined).
module tb_shift_seq_8bit;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [1:0] op;
    logic [2:0] amt;
    logic [7:0] in;
    logic [7:0] out;
    logic       busy;
    logic       done;
`ifdef SHIFT_SEQ_ZERO_FLAG_EN
    logic       zero;
`endif

    int checks   = 0;
    int failures = 0;

    localparam logic [1:0] SLL = 2'b00;
    localparam logic [1:0] SRL = 2'b01;
    localparam logic [1:0] SRA = 2'b10;
    localparam logic [1:0] ROL = 2'b11;

    shift_seq_8bit #(.WIDTH(8), .AMT_W(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .op    (op),
        .amt   (amt),
        .in    (in),
        .out   (out),
        .busy  (busy),
`ifdef SHIFT_SEQ_ZERO_FLAG_EN
        .zero  (zero),
`endif
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Launch one operation, scramble inputs after acceptance, and check timing and result.
    task automatic run_op(input string tag, input logic [7:0] din, input logic [1:0] dop,
                          input logic [2:0] damt, input logic [7:0] exp, input logic exp_zero);
        in    = din;
        op    = dop;
        amt   = damt;
        start = 1'b1;
        tick();
        start = 1'b0;
        in    = ~din;
        op    = ~dop;
        amt   = ~damt;
        chk({tag, ":busy_after_accept"}, {31'd0, busy}, 32'd1);
        chk({tag, ":done_after_accept"}, {31'd0, done}, 32'd0);
        for (int i = 0; i < int'(damt); i++) begin
            tick();
            if (done !== 1'b0) chk({tag, ":early_done"}, {31'd0, done}, 32'd0);
        end
        tick();
        $display("op %s in=0x%02h op=%0d amt=%0d out=0x%02h done=%0b", tag, din, dop, damt, out, done);
        chk({tag, ":done_pulse"}, {31'd0, done}, 32'd1);
        chk({tag, ":out"}, {24'd0, out}, {24'd0, exp});
`ifdef SHIFT_SEQ_ZERO_FLAG_EN
        chk({tag, ":zero"}, {31'd0, zero}, {31'd0, exp_zero});
`else
        if (exp_zero !== (exp == 8'h00)) $display("note: %s zero expectation inconsistent", tag);
`endif
        tick();
        chk({tag, ":done_low"}, {31'd0, done}, 32'd0);
        chk({tag, ":busy_low"}, {31'd0, busy}, 32'd0);
    endtask

    int done_cnt;

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        op    = SLL;
        amt   = 3'd0;
        in    = 8'h00;
        #12;
        chk("reset:out",  {24'd0, out},  32'h0);
        chk("reset:busy", {31'd0, busy}, 32'd0);
        chk("reset:done", {31'd0, done}, 32'd0);
`ifdef SHIFT_SEQ_ZERO_FLAG_EN
        chk("reset:zero", {31'd0, zero}, 32'd0);
`endif
        #1;
        rst_n = 1'b1;
        tick();

        run_op("rol81_1",  8'h81, ROL, 3'd1, 8'h03, 1'b0);
        run_op("sra96_3",  8'h96, SRA, 3'd3, 8'hF2, 1'b0);
        run_op("srl96_3",  8'h96, SRL, 3'd3, 8'h12, 1'b0);
        run_op("sllFF_7",  8'hFF, SLL, 3'd7, 8'h80, 1'b0);
        run_op("sll5A_0",  8'h5A, SLL, 3'd0, 8'h5A, 1'b0);
        run_op("rolB4_7",  8'hB4, ROL, 3'd7, 8'h5A, 1'b0);
        run_op("sra74_2",  8'h74, SRA, 3'd2, 8'h1D, 1'b0);
        run_op("srl01_1",  8'h01, SRL, 3'd1, 8'h00, 1'b1);
        run_op("srl03_1",  8'h03, SRL, 3'd1, 8'h01, 1'b0);

        // Result held while idle
        repeat (3) tick();
        chk("hold:out", {24'd0, out}, 32'h01);

        // Start re-asserted while busy is ignored
        in = 8'h0F; op = SLL; amt = 3'd4; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        start = 1'b1; in = 8'hAA; op = SRL; amt = 3'd1;
        tick(); tick(); tick();
        start = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            if (done === 1'b1) done_cnt++;
            tick();
        end
        $display("ignore-start out=0x%02h done_pulses=%0d", out, done_cnt);
        chk("ignore:out", {24'd0, out}, 32'hF0);
        chk("ignore:done_count", done_cnt, 32'd1);

        // Asynchronous reset mid-SHIFT aborts the operation
        in = 8'hF0; op = SRL; amt = 3'd5; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        $display("async-reset out=0x%02h busy=%0b done=%0b", out, busy, done);
        chk("areset:out",  {24'd0, out},  32'h0);
        chk("areset:busy", {31'd0, busy}, 32'd0);
        chk("areset:done", {31'd0, done}, 32'd0);
        tick();
        #2;
        rst_n = 1'b1;
        done_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (done === 1'b1) done_cnt++;
        end
        chk("areset:no_done", done_cnt, 32'd0);
        run_op("post_reset_srlF0_5", 8'hF0, SRL, 3'd5, 8'h07, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
